// File: rtl/henry_test_pio_pkg.sv
// Shared definitions for the henry_test PIO family.
//   BUS_W          : Avalon-MM data bus width
//   addr_e         : word address map of the input PIO
//   EDGE_*         : encodings for the EDGE_TYPE parameter
//   cnt_width()    : debounce counter width for a given cycle count
package henry_test_pio_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Counter has to reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/henry_test_input_pio_if.sv
// Avalon-MM slave bus bundle for the input PIO.
//   address    : word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : combinational read data
interface henry_test_input_pio_if;
    import henry_test_pio_pkg::*;

    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [BUS_W-1:0] writedata;
    logic [BUS_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/henry_test_pio_debounce.sv
// Single-bit two-flop synchroniser followed by a stability counter.
//   clk, reset_n : clock, async active-low reset
//   i_in         : asynchronous input bit
//   o_deb        : debounced, synchronised level
module henry_test_pio_debounce
    import henry_test_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_deb
);

    logic r_sync1;
    logic r_sync2;
    logic r_deb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) r_deb <= 1'b0;
                else          r_deb <= r_sync2;
            end
        end else begin : g_count
            localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] r_cnt;

            // Any sample equal to the accepted level restarts the count, so
            // only an unbroken run of DEBOUNCE_CYCLES differing samples flips it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == LAST) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    endgenerate

    assign o_deb = r_deb;

endmodule

// File: rtl/henry_test_input_pio.sv
// Avalon-MM input PIO: synchronises and debounces in_port, captures the
// selected edge per bit into sticky W1C bits, raises a masked level irq.
//   clk, reset_n : clock, async active-low reset
//   bus          : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port      : asynchronous external inputs
//   irq          : |(edge_capture & irq_mask)
module henry_test_input_pio
    import henry_test_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic                   clk,
    input  logic                   reset_n,
    henry_test_input_pio_if.slave  bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] r_deb_d;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic [BUS_W-1:0] w_rd;
    logic             w_wr;
    logic             w_unused_wdata;
    addr_e            w_addr;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            henry_test_pio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk     (clk),
                .reset_n (reset_n),
                .i_in    (in_port[i]),
                .o_deb   (w_deb[i])
            );
        end
    endgenerate

    assign w_addr         = addr_e'(bus.address);
    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_wdata        = bus.writedata[WIDTH-1:0];
    assign w_unused_wdata = ^bus.writedata;

    always_comb begin
        w_edge = w_deb & ~r_deb_d;
        case (EDGE_TYPE)
            EDGE_FALLING: w_edge = ~w_deb & r_deb_d;
            EDGE_ANY:     w_edge = w_deb ^ r_deb_d;
            default:      w_edge = w_deb & ~r_deb_d;
        endcase
    end

    assign w_clr = (w_wr && w_addr == ADDR_EDGECAP) ? w_wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_d <= '0;
            r_mask  <= '0;
            r_cap   <= '0;
        end else begin
            r_deb_d <= w_deb;
            if (w_wr && w_addr == ADDR_IRQMASK) r_mask <= w_wdata;
            // OR-ing the new edges after the clear lets a same-cycle set win.
            r_cap <= (r_cap & ~w_clr) | w_edge;
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_addr)
            ADDR_DATA:    w_rd = BUS_W'(w_deb);
            ADDR_IRQMASK: w_rd = BUS_W'(r_mask);
            ADDR_EDGECAP: w_rd = BUS_W'(r_cap);
            default:      w_rd = '0;
        endcase
    end

    assign bus.readdata = w_rd;
    assign irq          = |(r_cap & r_mask);

endmodule

// File: tb/tb_henry_test_input_pio.sv
// Self-checking bench for henry_test_input_pio (WIDTH=8, DEBOUNCE_CYCLES=4,
// rising edge). Directed steps with fixed expectations, then random
// stimulus compared every cycle against a window-based reference model.
module tb_henry_test_input_pio;

    localparam int W  = 8;
    localparam int DC = 4;
    localparam int ET = 0;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic         irq;

    henry_test_input_pio_if bus_if ();

    henry_test_input_pio #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .EDGE_TYPE       (ET)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [W-1:0] m_s1, m_s2, m_deb, m_deb_d, m_cap, m_mask;
    logic [W-1:0] m_win [DC];   // synchronised samples seen at the last DC edges

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_d = '0; m_cap = '0; m_mask = '0;
        for (int k = 0; k < DC; k++) m_win[k] = '0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_cap);
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock edge; the model consumes the inputs present at the edge.
    task automatic tick();
        logic [W-1:0] e, clr, deb_n;
        logic         wr;
        int           ones;
        @(posedge clk);
        if (!reset_n) begin
            model_clear();
        end else begin
            wr = bus_if.chipselect && !bus_if.write_n;
            case (ET)
                1:       e = ~m_deb & m_deb_d;
                2:       e = m_deb ^ m_deb_d;
                default: e = m_deb & ~m_deb_d;
            endcase
            clr = (wr && bus_if.address == 2'd3) ? bus_if.writedata[W-1:0] : '0;
            for (int k = DC - 1; k > 0; k--) m_win[k] = m_win[k-1];
            m_win[0] = m_s2;
            // A bit flips once DC consecutive samples all disagree with it.
            deb_n = m_deb;
            for (int b = 0; b < W; b++) begin
                ones = 0;
                for (int k = 0; k < DC; k++) ones += int'(m_win[k][b]);
                if (ones == DC && !m_deb[b]) deb_n[b] = 1'b1;
                if (ones == 0  &&  m_deb[b]) deb_n[b] = 1'b0;
            end
            m_cap = (m_cap & ~clr) | e;
            if (wr && bus_if.address == 2'd2) m_mask = bus_if.writedata[W-1:0];
            m_deb_d = m_deb;
            m_deb   = deb_n;
            m_s2    = m_s1;
            m_s1    = in_port;
        end
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rdc(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus_if.address = a;
        #1;
        chk(tag, bus_if.readdata, exp);
    endtask

    task automatic irqc(input logic exp, input string tag);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic chk_all();
        for (int a = 0; a < 4; a++) rdc(2'(a), exp_rd(2'(a)), $sformatf("model_rd%0d", a));
        irqc(|(m_cap & m_mask), "model_irq");
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk_all();
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = a;
        bus_if.writedata  = d;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        chk_all();
    endtask

    initial begin
        reset_n = 1'b0;
        in_port = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 2'd0;
        bus_if.writedata  = '0;
        model_clear();

        // Reset state
        run(2);
        rdc(0, 0, "rst_data"); rdc(2, 0, "rst_mask"); rdc(3, 0, "rst_cap"); irqc(0, "rst_irq");
        reset_n = 1'b1;

        // Reserved word ignores writes
        wr(1, 32'hFF);
        rdc(1, 0, "rsvd_rd");

        // Debounce latency and capture, mask 0
        in_port = 8'h05;
        run(5);
        rdc(0, 32'h00, "lat_data_e5");
        run(1);
        rdc(0, 32'h05, "lat_data_e6"); rdc(3, 32'h00, "lat_cap_e6");
        run(1);
        rdc(3, 32'h05, "lat_cap_e7"); irqc(0, "lat_irq_masked");

        // Masked irq on bit 0 and W1C clear
        wr(3, 32'hFF);
        in_port = 8'h04;
        run(8);
        rdc(3, 32'h00, "fall_ignored");
        wr(2, 32'h01);
        irqc(0, "mask_no_pending");
        in_port = 8'h05;
        run(6);
        irqc(0, "irq_e6");
        run(1);
        irqc(1, "irq_e7"); rdc(3, 32'h01, "cap_b0");
        wr(3, 32'h01);
        irqc(0, "irq_w1c"); rdc(3, 32'h00, "cap_w1c");

        // Glitch rejection (3 cycles) and acceptance (4 cycles)
        in_port = 8'h00;
        run(8);
        wr(3, 32'hFF);
        in_port = 8'h04;
        run(3);
        in_port = 8'h00;
        run(8);
        rdc(0, 32'h00, "glitch3_data"); rdc(3, 32'h00, "glitch3_cap");
        in_port = 8'h04;
        run(4);
        in_port = 8'h00;
        run(8);
        rdc(3, 32'h04, "pulse4_cap");
        wr(3, 32'hFF);

        // Same-cycle capture set and W1C clear: set wins
        in_port = 8'h01;
        run(8);
        in_port = 8'h00;
        run(8);
        wr(3, 32'h01);
        rdc(3, 32'h00, "pre_collide_cap");
        in_port = 8'h01;
        run(6);
        rdc(3, 32'h00, "collide_e6");
        wr(3, 32'h01);
        rdc(3, 32'h01, "collide_set_wins"); irqc(1, "collide_irq");
        wr(3, 32'h01);
        rdc(3, 32'h00, "collide_clear");

        // Input held high through reset release
        reset_n = 1'b0;
        model_clear();
        in_port = 8'h80;
        run(3);
        rdc(3, 0, "rst2_cap"); rdc(2, 0, "rst2_mask");
        reset_n = 1'b1;
        run(6);
        rdc(0, 32'h80, "held_data_e6"); rdc(3, 32'h00, "held_cap_e6");
        run(1);
        rdc(3, 32'h80, "held_cap_e7"); irqc(0, "held_irq");

        // Reset in the middle of a bit-1 debounce
        in_port = 8'h82;
        run(3);
        reset_n = 1'b0;
        model_clear();
        in_port = 8'h00;
        rdc(0, 0, "mid_rst_data"); rdc(2, 0, "mid_rst_mask"); rdc(3, 0, "mid_rst_cap");
        irqc(0, "mid_rst_irq");
        run(2);
        reset_n = 1'b1;
        run(10);
        rdc(0, 0, "mid_after_data"); rdc(3, 0, "mid_after_cap");

        // Random traffic against the model
        wr(2, 32'hFF);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) in_port = in_port ^ (W'($urandom) & W'($urandom));
            case ($urandom_range(0, 5))
                0: begin
                    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
                    bus_if.address = 2'($urandom_range(0, 3)); bus_if.writedata = $urandom;
                end
                1: begin
                    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b0;
                    bus_if.address = 2'($urandom_range(2, 3)); bus_if.writedata = $urandom;
                end
                default: begin
                    bus_if.chipselect = 1'($urandom_range(0, 1)); bus_if.write_n = 1'b1;
                    bus_if.writedata = $urandom;
                end
            endcase
            tick();
            bus_if.chipselect = 1'b0;
            bus_if.write_n    = 1'b1;
            chk_all();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/henry_test_input_pio.md
Name: henry_test_input_pio

Overview:
- Avalon-MM slave input PIO; the read-side counterpart to the LED output PIO.
- Samples an 8-bit external input (push-buttons/switches), synchronises and debounces it, and captures edges.
- Raises a maskable level interrupt to the Nios II.
- Sits on the same system interconnect as the output PIOs, with the same 2-bit word address and 32-bit data bus.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a new level; 0 bypasses debounce (use 4 in simulation).
- EDGE_TYPE, 0, capture edge: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  word address of the register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  read data, zero-extended.
- irq  output  1  level interrupt, active-high.

Behaviour:
- One clock, clk. reset_n is asynchronous, active-low, and clears every flop.
- Reset values: sync1, sync2, debounced, debounced_d, per-bit counters, irq_mask, edge_capture all 0. Therefore irq = 0 and readdata = 0 for every address during reset.
- Synchroniser: in_port -> sync1 -> sync2, two flops per bit.
- Debounce, per bit:
  - If sync2 == debounced, the counter clears.
  - Otherwise the counter increments.
  - When the counter is DEBOUNCE_CYCLES-1 and the bit still differs, debounced <= sync2 and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES), minimum 1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never reaches debounced.
  - DEBOUNCE_CYCLES = 0: debounced <= sync2 every cycle.
- Latency: in_port first sampled new at edge 1 -> debounced updates at edge 2+DEBOUNCE_CYCLES -> edge_capture bit and irq at edge 3+DEBOUNCE_CYCLES.
- Edge detect: debounced_d <= debounced each cycle.
  - rise = debounced & ~debounced_d
  - fall = ~debounced & debounced_d
  - EDGE_TYPE selects rise, fall, or rise|fall.
- Register map (word addresses):
  - 0 data: RO, debounced value, zero-extended.
  - 1 reserved: reads 0, writes ignored.
  - 2 irq_mask: RW, writedata[WIDTH-1:0].
  - 3 edge_capture: read returns capture bits; write clears each bit where writedata is 1 (W1C).
- Write = chipselect & ~write_n. Writes take effect at the next clk edge.
- Reads are combinational: readdata is a mux of address, valid in the same cycle, read latency 0. readdata is independent of chipselect.
- Capture set and W1C clear on the same bit in the same cycle: set wins, bit stays 1.
- Capture bits are sticky until cleared. Repeated edges on an already-set bit have no further effect.
- irq = |(edge_capture & irq_mask), combinational from registers.
  - Mask write to 0: irq drops next edge, capture bit preserved.
  - Mask write to 1 with a pending capture: irq rises next edge.
- Reset mid-debounce discards the partial count.
- An input held high through reset release produces a rising capture 3+DEBOUNCE_CYCLES edges after release. This is required behaviour.
- Bits above WIDTH-1 read 0 and ignore writes.

Decomposition:
- Shared package, henry_test_pio_pkg:
  - address constants: ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings
  - bus width 32
- One natural sub-module, henry_test_pio_debounce: single-bit synchroniser plus debounce counter, instantiated WIDTH times via generate.

Test Plan (DEBOUNCE_CYCLES=4, EDGE_TYPE=0):
- Reset then read addr 0/2/3 -> all 0x00000000, irq=0. Write addr 1 with 0xFF, read addr 1 -> 0.
- in_port 0x00->0x05 held -> addr 0 reads 0x05 from edge 6; edge_capture=0x05 at edge 7; irq stays 0 (mask 0).
- Mask=0x01 written, then in_port[0] rises -> irq=1 at edge 7. Write addr 3 with 0x01 -> irq=0 next edge, capture=0x00.
- in_port[2] 3-cycle pulse 0->1->0 -> data stays 0x00, capture stays 0x00.
- Capture bit 0 set, and a W1C of 0x01 lands in the same cycle a new rising edge on bit 0 sets it -> capture reads 0x01 afterwards.
- in_port held 0x80 through reset, reset_n released -> capture=0x80 at edge 7 after release. Assert reset_n mid-debounce of bit 1 -> no capture for bit 1, all registers 0.
